// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle for alu_seq: operand side (in_*, a, b, op)
// and result side (out_*, result, flags, busy).
interface alu_seq_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         ovf;
    logic         busy;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry, zero, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry, zero, ovf, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Registered W-bit ALU with valid/ready ports and flags. Define ALU_SEQ_MUL_EN
// to build the W-cycle shift-add multiplier; otherwise op 101 yields zero.
module alu_seq #(
    parameter int W = 8
) (
    input logic     clk,
    input logic     rst,
    alu_seq_if.slave bus
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_t;
`endif

    typedef struct packed {
        logic [W-1:0] result;
        logic         carry;
        logic         ovf;
    } single_t;

    function automatic single_t alu_single(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [2:0]   op
    );
        single_t    s;
        logic [W:0] wide;
        s    = '0;
        wide = '0;
        case (op)
            OP_ADD: begin
                wide     = {1'b0, a} + {1'b0, b};
                s.result = wide[W-1:0];
                s.carry  = wide[W];
                s.ovf    = (a[W-1] == b[W-1]) && (wide[W-1] != a[W-1]);
            end
            OP_SUB: begin
                wide     = {1'b0, a} - {1'b0, b};
                s.result = wide[W-1:0];
                s.carry  = wide[W];
                s.ovf    = (a[W-1] != b[W-1]) && (wide[W-1] != a[W-1]);
            end
            OP_AND: s.result = a & b;
            OP_OR:  s.result = a | b;
            OP_XOR: s.result = a ^ b;
            // The multiplier path never uses this value; without it op 101 reads as zero.
            OP_MUL: s.result = '0;
            OP_SHL: s.result = ({1'b0, b} >= (W+1)'(W)) ? '0 : (a << b);
            OP_SHR: s.result = ({1'b0, b} >= (W+1)'(W)) ? '0 : (a >> b);
            default: s.result = '0;
        endcase
        return s;
    endfunction

    state_t       state_q, state_d;
    logic [W-1:0] result_q, result_d;
    logic         carry_q, carry_d;
    logic         zero_q, zero_d;
    logic         ovf_q, ovf_d;
    logic         load_single;
    single_t      single;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(W);

    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] acc_step;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
`ifdef ALU_SEQ_MUL_EN
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        load_single = 1'b0;
        single      = alu_single(bus.a, bus.b, bus.op);
`ifdef ALU_SEQ_MUL_EN
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    if (bus.op == OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = {{W{1'b0}}, bus.a};
                        mplier_d = bus.b;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        load_single = 1'b1;
                    end
`else
                    load_single = 1'b1;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            // Step n adds a<<n when multiplier bit n is set; the last step lands in DONE.
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(W-1)) begin
                    state_d  = DONE;
                    result_d = acc_step[W-1:0];
                    carry_d  = |acc_step[2*W-1:W];
                    zero_d   = (acc_step[W-1:0] == '0);
                    ovf_d    = 1'b0;
                end
            end
`endif
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_single) begin
            state_d  = DONE;
            result_d = single.result;
            carry_d  = single.carry;
            zero_d   = (single.result == '0);
            ovf_d    = single.ovf;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
`ifdef ALU_SEQ_MUL_EN
    assign bus.busy      = (state_q == MUL);
`else
    assign bus.busy      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (W=8): directed cases followed by random operations checked
// against an integer-arithmetic model of the ALU rules.
module tb_alu_seq;

    localparam int W    = 8;
    localparam int MOD  = 1 << W;
    localparam int HALF = MOD / 2;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    alu_seq_if #(.W(W)) bus ();

    alu_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: integer arithmetic on the operand values, signed views for overflow.
    function automatic void model(input int a, input int b, input int op,
                                  output int r, output int c, output int z, output int v);
        int sa, sb, t;
        r  = 0;
        c  = 0;
        v  = 0;
        sa = (a >= HALF) ? a - MOD : a;
        sb = (b >= HALF) ? b - MOD : b;
        case (op)
            0: begin
                t = a + b;
                r = t % MOD;
                c = (t >= MOD) ? 1 : 0;
                t = sa + sb;
                v = (t > HALF - 1 || t < -HALF) ? 1 : 0;
            end
            1: begin
                r = (a - b + MOD) % MOD;
                c = (a < b) ? 1 : 0;
                t = sa - sb;
                v = (t > HALF - 1 || t < -HALF) ? 1 : 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin
                if (MUL_EN) begin
                    t = a * b;
                    r = t % MOD;
                    c = (t >= MOD) ? 1 : 0;
                end
            end
            6: r = (b >= W) ? 0 : ((a << b) % MOD);
            default: r = (b >= W) ? 0 : (a >> b);
        endcase
        z = (r == 0) ? 1 : 0;
    endfunction

    task automatic apply_stimulus(input int a, input int b, input int op, input string tag);
        check_output({tag, "/in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = W'(a);
        bus.b        = W'(b);
        bus.op       = 3'(op);
        tick();
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.op       = 3'($urandom);
    endtask

    task automatic await_result(input int op, input string tag);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            check_output({tag, "/busy"}, 32'(bus.busy), 32'd1);
            tick();
            n++;
        end
        check_output({tag, "/latency"}, 32'(n), (op == 5 && MUL_EN) ? 32'(W) : 32'd0);
    endtask

    task automatic check_result(input int a, input int b, input int op, input string tag);
        int r, c, z, v;
        model(a, b, op, r, c, z, v);
        check_output({tag, "/out_valid"}, 32'(bus.out_valid), 32'd1);
        check_output({tag, "/result"},    32'(bus.result),    32'(r));
        check_output({tag, "/carry"},     32'(bus.carry),     32'(c));
        check_output({tag, "/zero"},      32'(bus.zero),      32'(z));
        check_output({tag, "/ovf"},       32'(bus.ovf),       32'(v));
        check_output({tag, "/busy_done"}, 32'(bus.busy),      32'd0);
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_output({tag, "/out_valid_clr"}, 32'(bus.out_valid), 32'd0);
        check_output({tag, "/in_ready_ret"},  32'(bus.in_ready),  32'd1);
    endtask

    task automatic run_op(input int a, input int b, input int op, input int stall, input string tag);
        apply_stimulus(a, b, op, tag);
        await_result(op, tag);
        check_result(a, b, op, tag);
        for (int k = 0; k < stall; k++) begin
            tick();
            check_result(a, b, op, {tag, "/stall"});
        end
        release_result(tag);
    endtask

    initial begin
        int op, a, b;
        $display("[TB] alu_seq bench start, MUL_EN=%0d", MUL_EN);
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        tick();
        tick();
        check_output("reset/in_ready",  32'(bus.in_ready),  32'd1);
        check_output("reset/out_valid", 32'(bus.out_valid), 32'd0);
        check_output("reset/result",    32'(bus.result),    32'd0);
        check_output("reset/carry",     32'(bus.carry),     32'd0);
        check_output("reset/zero",      32'(bus.zero),      32'd0);
        check_output("reset/ovf",       32'(bus.ovf),       32'd0);
        check_output("reset/busy",      32'(bus.busy),      32'd0);
        rst = 1'b0;

        run_op(8'hF0, 8'h20, 0, 0, "add_carry");
        run_op(8'h7F, 8'h01, 0, 0, "add_ovf");
        run_op(8'h05, 8'h07, 1, 0, "sub_borrow");
        run_op(8'h80, 8'h01, 1, 0, "sub_ovf");
        run_op(8'h0C, 8'h0B, 5, 0, "mul_small");
        run_op(8'h20, 8'h10, 5, 0, "mul_wrap");
        run_op(8'hFF, 8'hFF, 5, 0, "mul_max");
        run_op(8'h01, 8'h08, 6, 0, "shl_by_w");
        run_op(8'h81, 8'h07, 6, 0, "shl_by_7");
        run_op(8'hC3, 8'h03, 7, 0, "shr_by_3");
        run_op(8'hC3, 8'hFF, 7, 0, "shr_big");

        // Back-pressure: result holds and offered ops are ignored while DONE waits.
        apply_stimulus(8'hAA, 8'hFF, 4, "bp");
        await_result(4, "bp");
        check_result(8'hAA, 8'hFF, 4, "bp");
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.a        = W'($urandom);
            bus.b        = W'($urandom);
            bus.op       = 3'd0;
            tick();
            check_output("bp/result_hold", 32'(bus.result),    32'h55);
            check_output("bp/valid_hold",  32'(bus.out_valid), 32'd1);
            check_output("bp/in_ready",    32'(bus.in_ready),  32'd0);
        end
        bus.in_valid = 1'b0;
        release_result("bp");
        tick();
        check_output("bp/no_ghost_op", 32'(bus.out_valid), 32'd0);

        // Reset four cycles into a multiply (or while its result waits, without MUL).
        apply_stimulus(8'h0C, 8'h0B, 5, "rst_mid");
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("rst_mid/out_valid", 32'(bus.out_valid), 32'd0);
        check_output("rst_mid/in_ready",  32'(bus.in_ready),  32'd1);
        check_output("rst_mid/busy",      32'(bus.busy),      32'd0);
        check_output("rst_mid/result",    32'(bus.result),    32'd0);
        check_output("rst_mid/carry",     32'(bus.carry),     32'd0);
        check_output("rst_mid/zero",      32'(bus.zero),      32'd0);
        check_output("rst_mid/ovf",       32'(bus.ovf),       32'd0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check_output("rst_mid/never_presented", 32'(bus.out_valid), 32'd0);
        end
        run_op(1, 1, 0, 0, "after_rst_add");

        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 7));
            a  = int'($urandom_range(0, MOD - 1));
            b  = (op >= 6) ? int'($urandom_range(0, W + 2)) : int'($urandom_range(0, MOD - 1));
            run_op(a, b, op, int'($urandom_range(0, 2)), $sformatf("rand%0d_op%0d", i, op));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's 2-bit combinational ALU. It accepts one W-bit operation per valid/ready handshake and returns the result with carry, zero and overflow flags on a registered, back-pressurable output port. Single-cycle operations complete one cycle after acceptance. The optional multiply runs as a W-cycle shift-add sequence. The block sits between an operand/decoder stage and a result writeback stage in the datapath exercises.

## Interface
- W, default 8: operand and result width in bits; minimum 2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  W  operand A, unsigned or two's complement per op.
- b  in  W  operand B; also the shift amount for shifts.
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 SHL, 111 SHR (logical).
- out_valid  out  1  result, carry, zero and ovf are valid.
- out_ready  in  1  consumer takes the result.
- result  out  W  operation result.
- carry  out  1  ADD: carry out. SUB: borrow (a < b unsigned). MUL: any product bit above W-1 set. Otherwise 0.
- zero  out  1  result == 0.
- ovf  out  1  signed overflow for ADD/SUB; 0 for all other ops.
- busy  out  1  state is MUL.

## Operation
- States are IDLE, MUL and DONE.
- **IDLE:** in_ready = 1. On in_valid & in_ready, capture a, b and op into internal registers; later changes to the inputs have no effect.
  - op other than MUL: compute from the captured operands, register result and flags, and go to DONE.
  - MUL: clear the product accumulator and go to MUL.
- **MUL:** one shift-add step per cycle over a 2W-bit accumulator for exactly W cycles, then go to DONE.
  - result = product[W-1:0].
  - carry = |product[2W-1:W].
- **DONE:** out_valid = 1. Outputs hold stable until out_ready = 1. On that edge, go to IDLE with out_valid = 0.
- in_valid is ignored outside IDLE. No new operation is accepted in the DONE→IDLE handoff cycle.
- Arithmetic:
  - ADD: {carry, result} = a + b.
  - SUB: {carry, result} = a - b, computed at W+1 bits.
  - ovf for ADD: the operands have equal sign bits and the result sign differs.
  - ovf for SUB: the operand sign bits differ and the result sign differs from a.
- Shifts: the amount is b as an unsigned value. An amount ≥ W yields result 0. carry = 0.
- Every op defines all outputs. No output retains a stale value across operations.
- **Reset:** state = IDLE. in_ready = 1 (combinational from state). out_valid = 0, result = 0, carry = 0, zero = 0, ovf = 0, busy = 0.
- **Reset mid-operation:** rst in MUL or DONE abandons the operation. The pending result is never presented.

## Timing
- Acceptance edge is cycle 0.
- Non-MUL ops: out_valid high from cycle 1.
- MUL: busy high from cycle 1 through cycle W. out_valid high from cycle W+1.
- Maximum throughput is one op every 2 cycles for non-MUL ops with out_ready tied high.
- With out_ready low, DONE persists indefinitely with all outputs stable.
- zero is registered together with result, never computed from a stale value.

## Configuration
- Macro: ALU_SEQ_MUL_EN.
- **Defined:** MUL state and shift-add datapath are compiled in, with behaviour as above.
- **Undefined:** no MUL state or accumulator exists.
  - op 101 completes as a single-cycle op with result 0, carry 0, ovf 0 and zero 1.
  - busy is tied to 0.

## Test plan
- **ADD carry:** W=8, ADD a=0xF0, b=0x20 → cycle 1: result 0x10, carry 1, ovf 0, zero 0.
- **Overflow and borrow:** ADD 0x7F+0x01 → result 0x80, ovf 1, carry 0. SUB 0x05-0x07 → result 0xFE, carry 1, ovf 0.
- **MUL timing and carry (macro on):** MUL 0x0C×0x0B → busy cycles 1–8, out_valid cycle 9, result 0x84, carry 0. MUL 0x20×0x10 → result 0x00, carry 1, zero 1.
- **Back-pressure:** hold out_ready=0 for 5 cycles after XOR 0xAA^0xFF → result 0x55 stays stable, in_valid ignored, in_ready 0. Then out_ready=1 → IDLE next cycle.
- **Reset mid-MUL:** assert rst at cycle 4 of a MUL → next edge: IDLE, out_valid 0, all outputs 0. A following ADD 1+1 returns 0x02.
- **Shift boundary and macro off:** SHL 0x01 by 8 → result 0x00, zero 1. With the macro undefined, op 101 → cycle 1: result 0, zero 1, busy never high.
